dmem_slave_ctrl: RTL



---
 rtl/dmem_slave_pkg.sv | 14 +
 rtl/dmem_slave_if.sv | 27 ++
 rtl/dmem_bram_be.sv | 28 ++
 rtl/dmem_slave_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/dmem_slave_pkg.sv
// Shared types and constants for the data-memory slave.
// State encoding, counter width and default error read data.
package dmem_slave_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GNT_WAIT = 2'd1,
        S_RESP     = 2'd2
    } state_t;

    localparam int          CNT_W         = 8;
    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_slave_if.sv
// req/gnt/rvalid data-port bundle between the load/store unit
// and the memory-side slave.
interface dmem_slave_if;

    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        err_o;

    modport master (
        output data_req_i, data_addr_i, data_we_i,
        output data_be_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, err_o
    );

    modport slave (
        input  data_req_i, data_addr_i, data_we_i,
        input  data_be_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, err_o
    );

endinterface

// File: rtl/dmem_bram_be.sv
// Single-port word array with per-byte write enables and a
// registered read port (read-before-write on the same address).
module dmem_bram_be #(
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= din[8*i +: 8];
                end
            end
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_slave_ctrl.sv
// Latency-programmable data-memory slave: grant/response FSM,
// range check and response mux around a byte-enabled word array.
module dmem_slave_ctrl
    import dmem_slave_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_2800,
    parameter int          DEPTH_WORDS    = 2048,
    parameter int          GNT_LATENCY    = 0,
    parameter int          RVALID_LATENCY = 1,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    dmem_slave_if.slave bus,
    output logic        busy_o
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rvalid_q, rvalid_d;
    logic             txn_we_q, txn_we_d;
    logic             txn_err_q, txn_err_d;

    logic [31:0]      off;
    logic             in_range;
    logic [AW-1:0]    idx;
    logic             gnt;
    logic [31:0]      ram_dout;
    logic [31:0]      rdata;
    logic             unused_off;

    // Below-base addresses wrap to large offsets and fail the compare.
    assign off        = bus.data_addr_i - BASE_ADDR;
    assign in_range   = off < SPAN;
    assign idx        = off[AW+1:2];
    assign unused_off = ^off[1:0];

    always_comb begin
        gnt = 1'b0;
        if (reset_n && bus.data_req_i) begin
            unique case (1'b1)
                (state_q == S_IDLE):     gnt = (GNT_LATENCY == 0);
                (state_q == S_GNT_WAIT): gnt = (cnt_q == CNT_W'(1));
                default:                 gnt = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rvalid_d  = 1'b0;
        txn_we_d  = txn_we_q;
        txn_err_d = txn_err_q;
        if (gnt) begin
            state_d   = S_RESP;
            cnt_d     = CNT_W'(RVALID_LATENCY);
            rvalid_d  = (RVALID_LATENCY == 1);
            txn_we_d  = bus.data_we_i;
            txn_err_d = !in_range;
        end else begin
            unique case (1'b1)
                (state_q == S_IDLE): begin
                    if (bus.data_req_i && GNT_LATENCY > 0) begin
                        state_d = S_GNT_WAIT;
                        cnt_d   = CNT_W'(GNT_LATENCY);
                    end
                end
                (state_q == S_GNT_WAIT): begin
                    if (!bus.data_req_i) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                (state_q == S_RESP): begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d    = cnt_q - CNT_W'(1);
                        rvalid_d = (cnt_q == CNT_W'(2));
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rvalid_q  <= 1'b0;
            txn_we_q  <= 1'b0;
            txn_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rvalid_q  <= rvalid_d;
            txn_we_q  <= txn_we_d;
            txn_err_q <= txn_err_d;
        end
    end

    dmem_bram_be #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk  (clk),
        .en   (gnt & in_range),
        .we   ({4{bus.data_we_i}} & bus.data_be_i),
        .addr (idx),
        .din  (bus.data_wdata_i),
        .dout (ram_dout)
    );

    // RAM output holds from the grant edge until the next grant.
    always_comb begin
        rdata = '0;
        if (rvalid_q && !txn_we_q) begin
            rdata = txn_err_q ? ERR_RDATA : ram_dout;
        end
    end

    assign bus.data_gnt_o    = gnt;
    assign bus.data_rvalid_o = rvalid_q;
    assign bus.data_rdata_o  = rdata;
    assign bus.err_o         = rvalid_q & txn_err_q;
    assign busy_o            = (state_q != S_IDLE);

endmodule
